// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/forwarding controller.
//   - FWD_* : forward-select encodings presented to the EXE operand muxes
//   - BR_STAGE_* : legal values of the branch-resolution stage parameter
//   - slot_t : one shadow-pipeline entry describing an in-flight register write
//   - slot_hit() : source-operand match rule against one shadow slot
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;  // read the register file
  localparam logic [1:0] FWD_MEM  = 2'd1;  // ALU result now in MEM
  localparam logic [1:0] FWD_WB   = 2'd2;  // write-back data
  localparam logic [1:0] FWD_RET  = 2'd3;  // retired-write holding register

  localparam int BR_STAGE_EXE = 2;
  localparam int BR_STAGE_MEM = 3;

  // Destination field is sized for the widest supported register file; narrower
  // configurations keep the upper bits at zero so comparisons stay exact.
  localparam int SLOT_AW_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic                   wen;
    logic [SLOT_AW_MAX-1:0] dst;
    logic                   is_load;
  } slot_t;

  // A source hits a slot only for a real write to a non-zero register.
  function automatic logic slot_hit(input slot_t s, input logic used,
                                    input logic [SLOT_AW_MAX-1:0] src);
    return used && s.valid && s.wen && (s.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_shadow_slot.sv
// -----------------------------------------------------------------------------
// hazard_shadow_slot
// One entry of the shadow pipeline. A clear loads all zeros and takes priority
// over the enable; with neither, the entry holds.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage enable, load d
//   clr        : synchronous stage clear, load zeros
//   d / q      : next entry from the stage ahead / current entry
// -----------------------------------------------------------------------------
module hazard_shadow_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  slot_t d,
  output slot_t q
);

  slot_t slot_d;
  slot_t slot_q;

  // Next-state selection: clear, load or hold.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (en) begin
      slot_d = d;
    end else begin
      slot_d = slot_q;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and forwarding controller for a 5-stage MIPS pipeline. Tracks in-flight
// register writes in a shadow pipeline (EXE/MEM/WB/RET) and drives the stage
// enables/clears, per-operand forward selects and the load-use stall.
// Ports:
//   id_*            : decoded ID-stage instruction (sources, destination, kind)
//   br_taken        : branch in stage BR_STAGE redirects the PC
//   mem_busy        : data memory not ready, freeze everything
//   *_en / *_rst    : stage enables / synchronous active-high stage clears
//   fwd_sel         : 2 bits per source operand, FWD_* encoding
//   load_stall      : load-use bubble inserted this cycle
//   stall_cnt/flush_cnt : perf counters, built only when HAZARD_PERF_CNT_EN
//                         is defined, otherwise tied to zero
// Priority: mem_busy > br_taken > load-use. Control outputs are combinational.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic                      br_taken,
  input  logic                      mem_busy,
  output logic                      if_en,
  output logic                      id_en,
  output logic                      exe_en,
  output logic                      mem_en,
  output logic                      wb_en,
  output logic                      if_rst,
  output logic                      id_rst,
  output logic                      exe_rst,
  output logic                      mem_rst,
  output logic                      wb_rst,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      load_stall,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  slot_t exe_q, mem_q, wb_q, ret_q;
  slot_t id_slot_s;

  logic [SLOT_AW_MAX-1:0] src_ext_s;
  logic [NUM_SRC-1:0]     hit_exe_s, hit_mem_s, hit_wb_s;
  logic [NUM_SRC*2-1:0]   fwd_s;
  logic                   load_use_s;

  // Entry offered to the EXE slot by the instruction currently in ID.
  always_comb begin
    id_slot_s                 = '0;
    id_slot_s.valid           = id_valid;
    id_slot_s.wen             = id_wen;
    id_slot_s.dst[REG_AW-1:0] = id_dst_addr;
    id_slot_s.is_load         = id_is_load;
  end

  hazard_shadow_slot u_slot_exe (.clk(clk), .rst_n(rst_n), .en(exe_en), .clr(exe_rst), .d(id_slot_s), .q(exe_q));
  hazard_shadow_slot u_slot_mem (.clk(clk), .rst_n(rst_n), .en(mem_en), .clr(mem_rst), .d(exe_q),     .q(mem_q));
  hazard_shadow_slot u_slot_wb  (.clk(clk), .rst_n(rst_n), .en(wb_en),  .clr(wb_rst),  .d(mem_q),     .q(wb_q));
  // The retired entry moves with write-back and is never flushed.
  hazard_shadow_slot u_slot_ret (.clk(clk), .rst_n(rst_n), .en(wb_en),  .clr(1'b0),    .d(wb_q),      .q(ret_q));

  // The retired entry only models the holding register; nothing is compared against it.
  logic slot_unused;
  assign slot_unused = ^ret_q;

  // Per-operand match against each slot; the youngest producer wins.
  always_comb begin
    src_ext_s = '0;
    hit_exe_s = '0;
    hit_mem_s = '0;
    hit_wb_s  = '0;
    fwd_s     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ext_s               = '0;
      src_ext_s[REG_AW-1:0]   = id_src_addr[i*REG_AW +: REG_AW];
      hit_exe_s[i]            = slot_hit(exe_q, id_src_used[i], src_ext_s);
      hit_mem_s[i]            = slot_hit(mem_q, id_src_used[i], src_ext_s);
      hit_wb_s[i]             = slot_hit(wb_q,  id_src_used[i], src_ext_s);
      if (hit_exe_s[i]) begin
        fwd_s[i*2 +: 2] = FWD_MEM;
      end else if (hit_mem_s[i]) begin
        fwd_s[i*2 +: 2] = FWD_WB;
      end else if (hit_wb_s[i]) begin
        fwd_s[i*2 +: 2] = FWD_RET;
      end else begin
        fwd_s[i*2 +: 2] = FWD_NONE;
      end
    end
  end

  // A load still in EXE cannot forward; the consumer must wait one cycle.
  assign load_use_s = id_valid && exe_q.is_load && (|hit_exe_s);

  // Stage control with priority reset > mem_busy > br_taken > load-use > idle.
  always_comb begin
    if_en      = 1'b1;
    id_en      = 1'b1;
    exe_en     = 1'b1;
    mem_en     = 1'b1;
    wb_en      = 1'b1;
    if_rst     = 1'b0;
    id_rst     = 1'b0;
    exe_rst    = 1'b0;
    mem_rst    = 1'b0;
    wb_rst     = 1'b0;
    load_stall = 1'b0;
    fwd_sel    = fwd_s;
    if (!rst_n) begin
      if_en   = 1'b0;
      id_en   = 1'b0;
      exe_en  = 1'b0;
      mem_en  = 1'b0;
      wb_en   = 1'b0;
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
      fwd_sel = '0;
    end else if (mem_busy) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (br_taken) begin
      // IF stays enabled so the redirected PC is captured.
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      if (BR_STAGE == BR_STAGE_MEM) begin
        mem_rst = 1'b1;
      end else begin
        mem_rst = 1'b0;
      end
    end else if (load_use_s) begin
      if_en      = 1'b0;
      id_en      = 1'b0;
      exe_rst    = 1'b1;
      load_stall = 1'b1;
    end else begin
      load_stall = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Counter increments; a flush only counts when the pipe is not frozen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_stall || mem_busy) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (br_taken && !mem_busy) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It decides per-stage enables and clears, per-operand forward selects and load-use stalls, replacing fixed, hand-fed control with a self-tracking unit. It keeps a shadow pipeline of in-flight register writes (EXE/MEM/WB/retired) and drives the stage `*_en` / `*_rst` inputs of the datapath. It sits beside the datapath and is fed from the ID-stage decoder.

## Interface
- `REG_AW`, 5: register address width.
- `NUM_SRC`, 2: source operands checked per instruction; operand i occupies bits `[i*REG_AW +: REG_AW]`.
- `BR_STAGE`, 3: stage resolving branches (2 = EXE, 3 = MEM).
- `CNT_W`, 32: perf counter width.

Ports:
- `clk`  in  1  main clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_src_addr`  in  NUM_SRC*REG_AW  source register addresses.
- `id_src_used`  in  NUM_SRC  source i is actually read.
- `id_dst_addr`  in  REG_AW  destination register.
- `id_wen`  in  1  instruction writes a register.
- `id_is_load`  in  1  destination data comes from memory.
- `br_taken`  in  1  branch in stage BR_STAGE redirects the PC this cycle.
- `mem_busy`  in  1  data memory not ready; freeze the whole pipe.
- `if_en`, `id_en`, `exe_en`, `mem_en`, `wb_en`  out  1 each  stage enables.
- `if_rst`, `id_rst`, `exe_rst`, `mem_rst`, `wb_rst`  out  1 each  synchronous stage clears, active-high.
- `fwd_sel`  out  NUM_SRC*2  per-operand forward select, latched into EXE by the datapath.
- `load_stall`  out  1  load-use bubble inserted this cycle.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  perf counters (macro-gated).

## Operation
- **Shadow slots.** EXE, MEM, WB and RET each hold {valid, wen, dst, is_load}.
  - When a stage is enabled, its slot loads from the slot ahead of it.
  - EXE loads from the `id_*` inputs.
  - A cleared stage loads all zeros.
- **Match rule.** Source i matches a slot when `id_src_used[i]`, slot valid, slot wen, dst equal, and dst != 0. Register 0 never matches.
- **fwd_sel encoding**, meaning where the value lives when the consumer is in EXE:
  - 0: none, use the regfile.
  - 1: ALU result in MEM (producer in EXE slot).
  - 2: WB write data (producer in MEM slot).
  - 3: retired-write holding register (producer in WB slot).
  - If several slots match, the youngest wins (EXE > MEM > WB).
- **Load-use.** A source matching the EXE slot with is_load set, while `id_valid`:
  - `load_stall` = 1, `if_en` = `id_en` = 0, `exe_rst` = 1.
  - MEM and WB advance.
  - fwd_sel is recomputed next cycle and then selects 2.
- **Branch flush.** On `br_taken`:
  - Clear stages ID through BR_STAGE: `id_rst`, `exe_rst`, plus `mem_rst` when BR_STAGE = 3.
  - `if_en` = 1 so the PC redirects.
  - Shadow slots EXE..BR_STAGE are zeroed.
- **Priority:** `mem_busy` > `br_taken` > load-use.
  - `mem_busy`: all enables 0, no clears, shadow holds. `br_taken` must be held by the datapath until the freeze ends.
  - Flush and load-use in the same cycle: flush wins and `load_stall` = 0.
- **Idle:** all enables 1, all clears 0.

## Timing
- Enables, clears, `fwd_sel` and `load_stall` are combinational from inputs and shadow state, with zero latency.
- Shadow slots and counters update on `posedge clk`.
- Load-use costs exactly 1 bubble. A taken branch costs BR_STAGE bubbles.
- While `rst_n` = 0:
  - Slots and counters are 0.
  - All `*_rst` outputs = 1, all `*_en` = 0, `fwd_sel` = 0, `load_stall` = 0.
- Release is asynchronous-assert, so a reset asserted mid-stall or mid-flush aborts it cleanly.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `HAZARD_PERF_CNT_EN`, when defined:
  - `stall_cnt` increments on every cycle with `load_stall` = 1 or `mem_busy` = 1.
  - `flush_cnt` increments on every accepted `br_taken`.
- When undefined, both ports are tied to 0 and the counter registers are not built.

## Structure
- Package `hazard_pkg`:
  - FWD_NONE/FWD_MEM/FWD_WB/FWD_RET encodings.
  - BR_STAGE_EXE = 2, BR_STAGE_MEM = 3.
  - Shadow-slot struct typedef.
- Sub-module `hazard_shadow_slot`: one slot register with en/clr, instantiated 4×.

## Test plan
- Producer `add $3` in EXE slot, consumer `sub` reads $3 as src0 → `fwd_sel[1:0]` = 1. Then 1 / 2 / 3 on successive spacing of 1 / 2 / 3 instructions.
- `lw $5` in EXE slot, consumer reads $5 → `load_stall` = 1 and `exe_rst` = 1 for 1 cycle; next cycle `fwd_sel` = 2.
- Producer writes $0, consumer reads $0 → `fwd_sel` = 0 and no stall.
- BR_STAGE = 3, `br_taken` = 1 → `id_rst` = `exe_rst` = `mem_rst` = 1 and `if_en` = 1; `flush_cnt` goes 0 → 1 with the macro defined. Repeat with BR_STAGE = 2 → `mem_rst` = 0.
- `br_taken` and load-use together → flush only, `load_stall` = 0. With `mem_busy` = 1 also high → all enables 0, shadow unchanged.
- Drop `rst_n` mid-stall → all clears 1 immediately; after release with no inputs active, all enables 1 and counters 0.
